// File: rtl/spu_sched_pkg.sv
// Shared widths, FSM state type and counter helper for the SPU issue scoreboard.
package spu_sched_pkg;

  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned NUM_REGS   = 128;
  localparam int unsigned LAT_W      = 5;

  typedef enum logic {
    ST_PAIR,
    ST_ODD_PENDING
  } state_e;

  // Saturating decrement: zero stays zero.
  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
    return (v == '0) ? '0 : v - LAT_W'(1);
  endfunction

endpackage

// File: rtl/spu_issue_scoreboard_if.sv
// Decode-to-scoreboard pair handshake: slot descriptors in, issue decisions out.
interface spu_issue_scoreboard_if;
  import spu_sched_pkg::*;

  logic                  flush;
  logic                  pair_valid;
  logic                  pair_ready;
  logic                  even_valid;
  logic                  odd_valid;
  logic [REG_ADDR_W-1:0] ra_src_even;
  logic [REG_ADDR_W-1:0] rb_src_even;
  logic [REG_ADDR_W-1:0] rc_src_even;
  logic [REG_ADDR_W-1:0] ra_src_odd;
  logic [REG_ADDR_W-1:0] rb_src_odd;
  logic [REG_ADDR_W-1:0] rc_src_odd;
  logic [2:0]            src_use_even;
  logic [2:0]            src_use_odd;
  logic [REG_ADDR_W-1:0] dst_even;
  logic [REG_ADDR_W-1:0] dst_odd;
  logic                  wr_even;
  logic                  wr_odd;
  logic [LAT_W-1:0]      latency_even;
  logic [LAT_W-1:0]      latency_odd;
  logic                  issue_even;
  logic                  issue_odd;
  logic                  stall;

  modport master (
    output flush, pair_valid, even_valid, odd_valid,
    output ra_src_even, rb_src_even, rc_src_even,
    output ra_src_odd, rb_src_odd, rc_src_odd,
    output src_use_even, src_use_odd, dst_even, dst_odd,
    output wr_even, wr_odd, latency_even, latency_odd,
    input  pair_ready, issue_even, issue_odd, stall
  );

  modport slave (
    input  flush, pair_valid, even_valid, odd_valid,
    input  ra_src_even, rb_src_even, rc_src_even,
    input  ra_src_odd, rb_src_odd, rc_src_odd,
    input  src_use_even, src_use_odd, dst_even, dst_odd,
    input  wr_even, wr_odd, latency_even, latency_odd,
    output pair_ready, issue_even, issue_odd, stall
  );

endinterface

// File: rtl/spu_ready_counter_bank.sv
// Per-register countdown to forwardability, two load ports and two 3-way ready lookups.
module spu_ready_counter_bank
  import spu_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_ld0_en,
  input  logic [REG_ADDR_W-1:0]      i_ld0_addr,
  input  logic [LAT_W-1:0]           i_ld0_val,
  input  logic                       i_ld1_en,
  input  logic [REG_ADDR_W-1:0]      i_ld1_addr,
  input  logic [LAT_W-1:0]           i_ld1_val,
  input  logic [2:0][REG_ADDR_W-1:0] i_rd_addr_a,
  input  logic [2:0][REG_ADDR_W-1:0] i_rd_addr_b,
  output logic [2:0]                 o_rdy_a,
  output logic [2:0]                 o_rdy_b
);

  logic [LAT_W-1:0] r_cnt     [NUM_REGS];
  logic [LAT_W-1:0] w_cnt_nxt [NUM_REGS];

  // A load never shortens an outstanding count: the larger of load and decrement wins.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_cnt_nxt[r] = sat_dec(r_cnt[r]);
      if (i_ld0_en && (i_ld0_addr == REG_ADDR_W'(r)) && (i_ld0_val > w_cnt_nxt[r]))
        w_cnt_nxt[r] = i_ld0_val;
      if (i_ld1_en && (i_ld1_addr == REG_ADDR_W'(r)) && (i_ld1_val > w_cnt_nxt[r]))
        w_cnt_nxt[r] = i_ld1_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  always_comb begin
    o_rdy_a = '0;
    o_rdy_b = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      o_rdy_a[k] = (r_cnt[i_rd_addr_a[k]] == '0);
      o_rdy_b[k] = (r_cnt[i_rd_addr_b[k]] == '0);
    end
  end

endmodule

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue dependency scoreboard for the SPU even/odd pipes.
// Optional stall/split statistics ports when SPU_SCOREBOARD_STATS_EN is defined.
module spu_issue_scoreboard
  import spu_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  spu_issue_scoreboard_if.slave sb
`ifdef SPU_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          split_count
`endif
);

  state_e           r_state;
  logic [2:0]       w_rdy_even;
  logic [2:0]       w_rdy_odd;
  logic             w_even_ok;
  logic             w_odd_srcs_ok;
  logic             w_wr_even_eff;
  logic             w_odd_raw;
  logic             w_waw;
  logic             w_issue_even;
  logic             w_issue_odd;
  logic             w_pair_ready;
  logic             w_split;
  logic [LAT_W-1:0] w_ld_val_even;
  logic [LAT_W-1:0] w_ld_val_odd;

  assign w_ld_val_even = sat_dec(sb.latency_even);
  assign w_ld_val_odd  = sat_dec(sb.latency_odd);

  spu_ready_counter_bank u_bank (
    .clk         (clk),
    .reset       (reset),
    .i_ld0_en    (w_issue_even && sb.wr_even),
    .i_ld0_addr  (sb.dst_even),
    .i_ld0_val   (w_ld_val_even),
    .i_ld1_en    (w_issue_odd && sb.wr_odd),
    .i_ld1_addr  (sb.dst_odd),
    .i_ld1_val   (w_ld_val_odd),
    .i_rd_addr_a ({sb.rc_src_even, sb.rb_src_even, sb.ra_src_even}),
    .i_rd_addr_b ({sb.rc_src_odd, sb.rb_src_odd, sb.ra_src_odd}),
    .o_rdy_a     (w_rdy_even),
    .o_rdy_b     (w_rdy_odd)
  );

  assign w_even_ok     = &(w_rdy_even | ~sb.src_use_even);
  assign w_odd_srcs_ok = &(w_rdy_odd | ~sb.src_use_odd);
  assign w_wr_even_eff = sb.even_valid && sb.wr_even;

  // The even result is not yet in the scoreboard this cycle, so same-pair hazards are explicit.
  assign w_odd_raw = w_wr_even_eff &&
                     ((sb.src_use_odd[0] && (sb.ra_src_odd == sb.dst_even)) ||
                      (sb.src_use_odd[1] && (sb.rb_src_odd == sb.dst_even)) ||
                      (sb.src_use_odd[2] && (sb.rc_src_odd == sb.dst_even)));
  assign w_waw = w_wr_even_eff && sb.wr_odd && (sb.dst_even == sb.dst_odd);

  always_comb begin
    w_issue_even = 1'b0;
    w_issue_odd  = 1'b0;
    w_pair_ready = 1'b0;
    w_split      = 1'b0;
    if (!reset && !sb.flush && sb.pair_valid) begin
      unique case (r_state)
        ST_PAIR: begin
          if (!sb.even_valid || w_even_ok) begin
            w_issue_even = sb.even_valid;
            if (!sb.odd_valid || (w_odd_srcs_ok && !w_odd_raw && !w_waw)) begin
              w_issue_odd  = sb.odd_valid;
              w_pair_ready = 1'b1;
            end else if (sb.even_valid) begin
              w_split = 1'b1;
            end
          end
        end
        ST_ODD_PENDING: begin
          if (!sb.odd_valid || w_odd_srcs_ok) begin
            w_issue_odd  = sb.odd_valid;
            w_pair_ready = 1'b1;
          end
        end
      endcase
    end
  end

  assign sb.issue_even = w_issue_even;
  assign sb.issue_odd  = w_issue_odd;
  assign sb.pair_ready = w_pair_ready;
  assign sb.stall      = !reset && sb.pair_valid && !w_pair_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PAIR;
    end else if (sb.flush) begin
      r_state <= ST_PAIR;
    end else if (w_split) begin
      r_state <= ST_ODD_PENDING;
    end else if ((r_state == ST_ODD_PENDING) && w_pair_ready) begin
      r_state <= ST_PAIR;
    end
  end

  a_odd_pending_needs_pair : assert property (
    @(posedge clk) disable iff (reset) (r_state == ST_ODD_PENDING) |-> sb.pair_valid
  );

`ifdef SPU_SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_split_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_split_count  <= '0;
    end else begin
      if (sb.stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_split)  r_split_count  <= r_split_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign split_count  = r_split_count;
`endif

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed self-checking bench for spu_issue_scoreboard (stats checked when SPU_SCOREBOARD_STATS_EN is defined).
module tb_spu_issue_scoreboard;
  import spu_sched_pkg::*;

  typedef struct packed {
    logic       v;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic [2:0] use_m;
    logic [6:0] dst;
    logic       wr;
    logic [4:0] lat;
  } slot_t;

  localparam slot_t EMPTY = '0;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spu_issue_scoreboard_if u_if ();

`ifdef SPU_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] split_count;
`endif

  spu_issue_scoreboard u_dut (
    .clk          (clk),
    .reset        (reset),
    .sb           (u_if)
`ifdef SPU_SCOREBOARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .split_count  (split_count)
`endif
  );

  function automatic slot_t mk(input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                               input logic [2:0] um, input logic [6:0] dst, input logic wr,
                               input logic [4:0] lat);
    mk = '{1'b1, ra, rb, rc, um, dst, wr, lat};
  endfunction

  function automatic slot_t rd(input logic [6:0] r);
    rd = mk(r, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 5'd0);
  endfunction

  function automatic slot_t wrs(input logic [6:0] d, input logic [4:0] l);
    wrs = mk(7'd0, 7'd0, 7'd0, 3'b000, d, 1'b1, l);
  endfunction

  task automatic put(input slot_t e, input slot_t o);
    u_if.even_valid   = e.v;
    u_if.ra_src_even  = e.ra;
    u_if.rb_src_even  = e.rb;
    u_if.rc_src_even  = e.rc;
    u_if.src_use_even = e.use_m;
    u_if.dst_even     = e.dst;
    u_if.wr_even      = e.wr;
    u_if.latency_even = e.lat;
    u_if.odd_valid    = o.v;
    u_if.ra_src_odd   = o.ra;
    u_if.rb_src_odd   = o.rb;
    u_if.rc_src_odd   = o.rc;
    u_if.src_use_odd  = o.use_m;
    u_if.dst_odd      = o.dst;
    u_if.wr_odd       = o.wr;
    u_if.latency_odd  = o.lat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector is {issue_even, issue_odd, pair_ready, stall}.
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    #1;
    obs = {u_if.issue_even, u_if.issue_odd, u_if.pair_ready, u_if.stall};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    u_if.flush      = 1'b0;
    u_if.pair_valid = 1'b1;
    put(mk(7'd5, 7'd0, 7'd0, 3'b001, 7'd9, 1'b1, 5'd1), mk(7'd6, 7'd0, 7'd0, 3'b001, 7'd10, 1'b1, 5'd1));
    chk("reset_outputs", 4'b0000);
    tick();
    tick();
    reset = 1'b0;

    // independent pair 5/6 -> 9/10
    chk("indep_pair", 4'b1110);
    tick();

    // L=6 producer, dependent stalls cycles 1..5
    put(wrs(7'd3, 5'd6), EMPTY);
    chk("l6_producer", 4'b1010);
    tick();
    put(rd(7'd3), EMPTY);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("l6_stall_c%0d", i), 4'b0001);
      tick();
    end
    chk("l6_issue_c6", 4'b1010);
    tick();

    // L=1 back-to-back and L=0 treated as L=1
    put(wrs(7'd20, 5'd1), EMPTY);
    chk("l1_producer", 4'b1010);
    tick();
    put(rd(7'd20), EMPTY);
    chk("l1_back_to_back", 4'b1010);
    tick();
    put(wrs(7'd21, 5'd0), EMPTY);
    chk("l0_producer", 4'b1010);
    tick();
    put(rd(7'd21), EMPTY);
    chk("l0_as_l1", 4'b1010);
    tick();

    // odd reads even dst but even does not write: no hazard
    put(mk(7'd0, 7'd0, 7'd0, 3'b000, 7'd50, 1'b0, 5'd4), rd(7'd50));
    chk("nowr_no_raw", 4'b1110);
    tick();

    // intra-pair RAW on r12, L=2
    put(wrs(7'd12, 5'd2), rd(7'd12));
    chk("raw_split", 4'b1001);
    tick();
    chk("raw_wait", 4'b0001);
    tick();
    chk("raw_odd_issue", 4'b0110);
`ifdef SPU_SCOREBOARD_STATS_EN
    chk32("split_after_raw", split_count, 32'd1);
`endif
    tick();

    // WAW on r40: even L=3, odd L=5 one cycle later; counter follows odd
    put(wrs(7'd40, 5'd3), wrs(7'd40, 5'd5));
    chk("waw_even", 4'b1001);
    tick();
    chk("waw_odd", 4'b0110);
    tick();
    put(rd(7'd40), EMPTY);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("waw_stall_c%0d", i), 4'b0001);
      tick();
    end
    chk("waw_cnt_from_odd", 4'b1010);
`ifdef SPU_SCOREBOARD_STATS_EN
    chk32("split_after_waw", split_count, 32'd2);
`endif
    tick();

    // L=31: 30 stall cycles maximum
    put(wrs(7'd100, 5'd31), EMPTY);
    chk("l31_producer", 4'b1010);
    tick();
    put(rd(7'd100), EMPTY);
    for (int i = 1; i <= 30; i++) begin
      chk($sformatf("l31_stall_c%0d", i), 4'b0001);
      tick();
    end
    chk("l31_issue", 4'b1010);
    tick();

    // flush suppresses an otherwise ready pair
    put(mk(7'd70, 7'd0, 7'd0, 3'b001, 7'd72, 1'b1, 5'd1), mk(7'd71, 7'd0, 7'd0, 3'b001, 7'd73, 1'b1, 5'd1));
    u_if.flush = 1'b1;
    chk("flush_blocks", 4'b0001);
    tick();
    u_if.flush = 1'b0;
    chk("after_flush", 4'b1110);
    tick();

    // flush inside a stall; counter keeps decrementing
    put(wrs(7'd30, 5'd4), EMPTY);
    chk("fl_stall_prod", 4'b1010);
    tick();
    put(rd(7'd30), EMPTY);
    chk("fl_stall_c1", 4'b0001);
    tick();
    u_if.flush = 1'b1;
    chk("flush_in_stall", 4'b0001);
    tick();
    u_if.flush = 1'b0;
    chk("fl_stall_c3", 4'b0001);
    tick();
    chk("flush_stall_on_sched", 4'b1010);
    tick();

    // flush in ODD_PENDING returns to PAIR: even re-issues
    put(wrs(7'd60, 5'd3), rd(7'd60));
    chk("fl_pend_split", 4'b1001);
    tick();
    u_if.flush = 1'b1;
    chk("flush_odd_pend", 4'b0001);
    tick();
    u_if.flush = 1'b0;
    chk("flush_back_to_pair", 4'b1001);
    tick();
    chk("fl_pend_w1", 4'b0001);
    tick();
    chk("fl_pend_w2", 4'b0001);
    tick();
    chk("fl_pend_odd", 4'b0110);
    tick();

    // reset while ODD_PENDING with cnt[r7]=4
    put(wrs(7'd7, 5'd5), rd(7'd7));
    chk("rst_pend_split", 4'b1001);
    tick();
    chk("pend_before_reset", 4'b0001);
    reset = 1'b1;
    chk("reset_mid_pend", 4'b0000);
    tick();
    reset = 1'b0;
    put(rd(7'd7), EMPTY);
    chk("r7_after_reset", 4'b1010);
`ifdef SPU_SCOREBOARD_STATS_EN
    chk32("split_cleared", split_count, 32'd0);
    chk32("stall_cleared", stall_cycles, 32'd0);
`endif
    tick();

    // one stall cycle after reset
    put(wrs(7'd8, 5'd2), EMPTY);
    chk("post_rst_prod", 4'b1010);
    tick();
    put(rd(7'd8), EMPTY);
    chk("post_rst_stall", 4'b0001);
    tick();
    chk("post_rst_issue", 4'b1010);
`ifdef SPU_SCOREBOARD_STATS_EN
    chk32("stall_count_one", stall_cycles, 32'd1);
`endif
    tick();

    // pair_valid low: nothing issues, no stall
    u_if.pair_valid = 1'b0;
    put(mk(7'd5, 7'd0, 7'd0, 3'b001, 7'd90, 1'b1, 5'd1), mk(7'd6, 7'd0, 7'd0, 3'b001, 7'd91, 1'b1, 5'd1));
    chk("idle_no_issue", 4'b0000);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spu_issue_scoreboard.md
# spu_issue_scoreboard

Dual-issue dependency scoreboard for the SPU even/odd pipes. It sits between decode and register fetch and tracks when each of the 128 registers' pending results become forwardable. It stalls or splits an instruction pair until every source operand can be served from the register file or the forwarding network. Issued write metadata (dst, wr, latency) flows on into the stage registers that feed operand forwarding.

## Interface
- Parameters: none; widths come from the shared package.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  drops any held pair or half-pair; scoreboard counters are retained.
- pair_valid  in  1  decode presents a pair this cycle.
- pair_ready  out  1  pair consumed this cycle (combinational).
- even_valid, odd_valid  in  1 each  slot occupied.
- ra_src_even, rb_src_even, rc_src_even  in  7 each  even source regs.
- ra_src_odd, rb_src_odd, rc_src_odd  in  7 each  odd source regs.
- src_use_even, src_use_odd  in  3 each  bit0=ra, bit1=rb, bit2=rc used.
- dst_even, dst_odd  in  7 each  destination reg.
- wr_even, wr_odd  in  1 each  instruction writes dst.
- latency_even, latency_odd  in  5 each  cycles from issue until the result is forwardable.
- issue_even, issue_odd  out  1 each  slot issued this cycle (combinational).
- stall  out  1  pair_valid high and pair_ready low.

## Operation
- Bank of 128 5-bit ready counters, cnt[r]. A source r is ready iff cnt[r]==0.
- Each cycle, every nonzero counter decrements by 1.
- On issue of a writing slot with latency L, cnt[dst] <= max(sat(L-1), cnt[dst]-1 saturating at 0). The load takes priority over the plain decrement.
- For a producer issued in cycle t with latency L ≥ 1, a dependent may issue in cycle t+L. L=0 behaves as L=1.
- FSM states:
  - PAIR: even slot ready (all used sources ready) → issue_even. Odd slot issues in the same cycle only if all of the following hold: even issues (or even slot empty); all odd sources are ready; no odd source equals dst_even while wr_even is set; not (wr_even && wr_odd && dst_even==dst_odd).
  - PAIR, both issued (or empty): pair_ready=1, stay in PAIR.
  - PAIR, even issued but odd blocked: go to ODD_PENDING, pair_ready=0.
  - PAIR, even blocked: nothing issues; odd never bypasses even.
  - ODD_PENDING: only the odd slot is evaluated against the scoreboard. When it is ready, issue_odd=1, pair_ready=1, go to PAIR. Decode holds the pair inputs stable until pair_ready.
- flush: issue_* forced 0 that cycle, FSM → PAIR, counters still decrement.
- pair_valid low: no issue, FSM holds state. ODD_PENDING with pair_valid low is illegal and must be asserted in simulation.
- Register 0 gets no special treatment.

## Timing
- Reset values: all cnt=0, FSM=PAIR. issue_even, issue_odd, pair_ready, stall are 0 during reset.
- Issue decision is combinational on current counters and inputs, with zero-cycle latency. Counter and FSM updates are visible the next cycle.
- Back-to-back dependent with L=1: producer at t, consumer at t+1, no stall.
- Max stall for a single dependency is 30 cycles (L=31).
- A synchronous reset mid-stall or in ODD_PENDING discards the held slot. Counters are cleared, so in-flight producers lose tracking, which is acceptable because reset also clears the pipeline.

## Configuration
- SPU_SCOREBOARD_STATS_EN defined: adds outputs stall_cycles (32-bit) and split_count (32-bit).
  - stall_cycles increments on every cycle with stall=1.
  - split_count increments on every PAIR→ODD_PENDING transition.
  - Both wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent, with identical functional behaviour.

## Structure
- Package spu_sched_pkg:
  - REG_ADDR_W=7, NUM_REGS=128, LAT_W=5.
  - State enum {ST_PAIR, ST_ODD_PENDING}.
  - Function sat_dec.
- One sub-module, spu_ready_counter_bank:
  - 128 counters with two load ports (addr, value, enable) and per-cycle decrement.
  - Two 3-way combinational read-compare ports returning a ready mask per slot.
- Top holds the FSM, pair hazard checks, and the optional stats.

## Test plan
- Independent pair, both slots ready, regs 5/6 → 9/10 → issue_even=issue_odd=pair_ready=1 in the same cycle, no stall.
- Even writes r3 with L=6 at cycle 0; next pair's even reads r3 → stall on cycles 1–5, issue at cycle 6.
- Intra-pair RAW: even writes r12 (L=2), odd reads r12 → even issues at t, ODD_PENDING, odd issues at t+2, split_count=1.
- WAW: both slots write r40 → even at t, odd at t+1; cnt[r40] ends at the odd latency's value.
- Reset pulse while in ODD_PENDING with cnt[r7]=4 → next cycle FSM=PAIR, cnt all 0, and a reader of r7 issues immediately.
- flush during a 3-cycle stall → issue_* stay 0 that cycle, FSM=PAIR, and the remaining counter still reaches 0 on schedule.
